// File: rtl/alu_sequencer.sv
// alu_sequencer: hardwired Moore control unit sequencing fetch/execute of register-to-register ALU instructions.
module alu_sequencer #(
  parameter int NREGS = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic             pc_out,
  output logic             zlo_out,
  output logic             mdr_out,
  output logic             mar_enable,
  output logic             pc_enable,
  output logic             mdr_enable,
  output logic             ir_enable,
  output logic             y_enable,
  output logic             z_enable,
  output logic             pc_increment,
  output logic             read,
  output logic [4:0]       op_code,
  output logic [NREGS-1:0] r_in,
  output logic [NREGS-1:0] r_out,
  output logic             done,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, FAULT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic illegal_q;
  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic two_op, one_op, legal;
  assign opc = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign two_op = (opc >= 5'd3) && (opc <= 5'd11);
  assign one_op = (opc == 5'd17) || (opc == 5'd18);
  assign legal = two_op || one_op;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = run ? T0 : IDLE;
      T0:      state_d = T1;
      T1:      state_d = mem_ready ? T2 : T1;
      T2:      state_d = T3;
      T3:      state_d = legal ? T4 : FAULT;
      T4:      state_d = T5;
      T5:      state_d = run ? T0 : IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == T5) cnt_q <= cnt_q + 1'b1;
      if (state_q == T3 && !legal) illegal_q <= 1'b1;
    end
  end
  // IR fields are only trusted from T3 on, so every field-driven strobe is gated by state
  assign pc_out = state_q == T0;
  assign mar_enable = state_q == T0;
  assign pc_increment = state_q == T0;
  assign z_enable = (state_q == T0) || (state_q == T4);
  assign zlo_out = (state_q == T1) || (state_q == T5);
  assign pc_enable = state_q == T1;
  assign read = state_q == T1;
  assign mdr_enable = state_q == T1;
  assign mdr_out = state_q == T2;
  assign ir_enable = state_q == T2;
  assign y_enable = (state_q == T3) && two_op;
  assign op_code = (state_q == T4) ? opc : 5'd0;
  assign r_out = ((state_q == T3) && two_op) ? NREGS'(1) << rb :
                 (state_q == T4) ? NREGS'(1) << (two_op ? rc : rb) : '0;
  assign r_in = (state_q == T5) ? NREGS'(1) << ra : '0;
  assign done = state_q == T5;
  assign busy = (state_q != IDLE) && (state_q != FAULT);
  assign illegal = illegal_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed-vector bench for alu_sequencer with hand-computed expectations.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic clr, run, mem_ready;
  logic [31:0] ir;
  logic pc_out, zlo_out, mdr_out, mar_enable, pc_enable, mdr_enable, ir_enable;
  logic y_enable, z_enable, pc_increment, read, done, illegal, busy;
  logic [4:0] op_code;
  logic [15:0] r_in, r_out;
  logic [3:0] instr_count;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] IR_AND = 32'h5091_8000;
  localparam logic [31:0] IR_ADD = 32'h1891_8000;
  localparam logic [31:0] IR_NOT = 32'h9098_0000;
  localparam logic [31:0] IR_BAD = 32'hF800_0000;
  alu_sequencer #(.NREGS(16), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .zlo_out(zlo_out), .mdr_out(mdr_out),
    .mar_enable(mar_enable), .pc_enable(pc_enable), .mdr_enable(mdr_enable),
    .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable),
    .pc_increment(pc_increment), .read(read), .op_code(op_code),
    .r_in(r_in), .r_out(r_out), .done(done), .illegal(illegal),
    .busy(busy), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  logic any_out;
  assign any_out = |{pc_out, zlo_out, mdr_out, mar_enable, pc_enable, mdr_enable, ir_enable,
                     y_enable, z_enable, pc_increment, read, done, illegal, busy,
                     op_code, r_in, r_out, instr_count};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // Starts one instruction and walks it to the T3 negedge; waits = T1 cycles with mem_ready low.
  task automatic fetch(input logic [31:0] w, input int waits);
    @(negedge clk);
    run = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t0_pc_out", pc_out, 1);
    chk("t0_mar_en", mar_enable, 1);
    chk("t0_pc_inc", pc_increment, 1);
    chk("t0_z_en", z_enable, 1);
    run = 1'b0;
    mem_ready = (waits == 0);
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      chk("t1_read", read, 1);
      chk("t1_mdr_en", mdr_enable, 1);
      chk("t1_zlo_pc", {zlo_out, pc_enable}, 2'b11);
      chk("t1_no_ir_en", ir_enable, 0);
      if (k == waits) mem_ready = 1'b1;
    end
    @(negedge clk);
    chk("t2_strobes", {mdr_out, ir_enable, read}, 3'b110);
    ir = w;
    @(negedge clk);
  endtask
  initial begin
    int n, last;
    clr = 1'b1;
    run = 1'b0;
    mem_ready = 1'b1;
    ir = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_outs", any_out, 0);
    clr = 1'b0;
    @(negedge clk);
    chk("idle_outs", any_out, 0);
    fetch(IR_AND, 0);
    chk("and_t3_r_out", r_out, 16'h0004);
    chk("and_t3_y_en", y_enable, 1);
    chk("and_t3_r_in", r_in, 0);
    @(negedge clk);
    chk("and_t4_r_out", r_out, 16'h0008);
    chk("and_t4_op", op_code, 5'b01010);
    chk("and_t4_z_en", z_enable, 1);
    @(negedge clk);
    chk("and_t5_r_in", r_in, 16'h0002);
    chk("and_t5_done", done, 1);
    chk("and_t5_r_out", r_out, 0);
    chk("and_t5_op", op_code, 0);
    @(negedge clk);
    chk("and_idle_busy", busy, 0);
    chk("and_done_pulse", done, 0);
    chk("and_count", instr_count, 1);
    fetch(IR_AND, 3);
    chk("mw_t3_r_out", r_out, 16'h0004);
    @(negedge clk);
    chk("mw_t4_op", op_code, 5'b01010);
    @(negedge clk);
    chk("mw_t5_done", done, 1);
    @(negedge clk);
    chk("mw_count", instr_count, 2);
    fetch(IR_NOT, 0);
    chk("not_t3_r_out", r_out, 0);
    chk("not_t3_y_en", y_enable, 0);
    chk("not_t3_busy", busy, 1);
    @(negedge clk);
    chk("not_t4_r_out", r_out, 16'h0008);
    chk("not_t4_op", op_code, 5'b10010);
    @(negedge clk);
    chk("not_t5_r_in", r_in, 16'h0002);
    @(negedge clk);
    chk("not_count", instr_count, 3);
    fetch(IR_AND, 0);
    @(negedge clk);
    chk("rst_mid_t4_op", op_code, 5'b01010);
    clr = 1'b1;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_outs", any_out, 0);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_idle_quiet", any_out, 0);
    end
    ir = IR_ADD;
    run = 1'b1;
    n = 0;
    last = 0;
    for (int c = 1; c <= 200 && n < 17; c++) begin
      @(negedge clk);
      if (done) begin
        n++;
        if (n == 1) chk("b2b_first", c, 6);
        else chk("b2b_gap", c - last, 6);
        chk("b2b_r_in", r_in, 16'h0002);
        last = c;
        if (n == 16) chk("b2b_pre_wrap", instr_count, 15);
        if (n == 17) begin
          chk("b2b_wrapped", instr_count, 0);
          run = 1'b0;
        end
      end
    end
    chk("b2b_done_total", n, 17);
    @(negedge clk);
    chk("b2b_final_count", instr_count, 1);
    chk("b2b_idle", busy, 0);
    fetch(IR_BAD, 0);
    chk("bad_t3_r_out", r_out, 0);
    chk("bad_t3_busy", busy, 1);
    chk("bad_t3_illegal", illegal, 0);
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fault_illegal", illegal, 1);
      chk("fault_busy", busy, 0);
      chk("fault_r_in", r_in, 0);
      chk("fault_pc_out", pc_out, 0);
    end
    run = 1'b0;
    clr = 1'b1;
    #1;
    chk("fault_clr_illegal", illegal, 0);
    chk("fault_clr_count", instr_count, 0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("post_fault_idle", any_out, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
